// File: rtl/sign_extend.sv
// Registered parallel sign extension of DEPTH packed lanes, one-cycle latency.
// Ports: clk, rst_n (sync, active-low); validIn/zeroExt/dataIn in; dataOut/validOut out.
// Optional: define SIGNEXTEND_ZEXT_EN to honour per-lane zeroExt requests.
module sign_extend #(
  parameter int DATA_WIDTH_IN  = 16,
  parameter int DEPTH          = 4,
  parameter int DATA_WIDTH_OUT = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            validIn,
  input  logic [DEPTH-1:0]                zeroExt,
  input  logic [DATA_WIDTH_IN*DEPTH-1:0]  dataIn,
  output logic [DATA_WIDTH_OUT*DEPTH-1:0] dataOut,
  output logic                            validOut
);

  if (DATA_WIDTH_OUT < DATA_WIDTH_IN) begin : g_bad_width
    $error("sign_extend: DATA_WIDTH_OUT must be >= DATA_WIDTH_IN");
  end

  logic [DATA_WIDTH_OUT*DEPTH-1:0] w_ext;
  logic [DATA_WIDTH_OUT*DEPTH-1:0] r_data;
  logic                            r_valid;

  // zeroExt has no effect in some builds/widths; keep it referenced.
  logic w_unused_zext;
  assign w_unused_zext = ^zeroExt;

  for (genvar i = 0; i < DEPTH; i++) begin : g_lane
    logic [DATA_WIDTH_IN-1:0] w_lane;
    assign w_lane = dataIn[i*DATA_WIDTH_IN +: DATA_WIDTH_IN];

    if (DATA_WIDTH_OUT == DATA_WIDTH_IN) begin : g_pass
      assign w_ext[i*DATA_WIDTH_OUT +: DATA_WIDTH_OUT] = w_lane;
    end else begin : g_wide
      logic w_fill;
`ifdef SIGNEXTEND_ZEXT_EN
      assign w_fill = w_lane[DATA_WIDTH_IN-1] & ~zeroExt[i];
`else
      assign w_fill = w_lane[DATA_WIDTH_IN-1];
`endif
      assign w_ext[i*DATA_WIDTH_OUT +: DATA_WIDTH_OUT] =
        {{(DATA_WIDTH_OUT-DATA_WIDTH_IN){w_fill}}, w_lane};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= validIn;
      if (validIn) begin
        r_data <= w_ext;
      end
    end
  end

  assign dataOut  = r_data;
  assign validOut = r_valid;

endmodule

// File: tb/tb_sign_extend.sv
// Scoreboard bench for sign_extend: default build plus two 8-bit single-lane
// instances (pass-through 8->8 and 8->12).
module tb_sign_extend;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         validIn;
  logic [3:0]   zeroExt;
  logic [63:0]  dataIn;
  logic [127:0] dataOut;
  logic         validOut;
  logic [0:0]   zx1;
  logic [7:0]   d8;
  logic [7:0]   out8;
  logic [11:0]  out12;
  logic         v8;
  logic         v12;

  always #5 clk = ~clk;

  sign_extend dut (
    .clk(clk), .rst_n(rst_n), .validIn(validIn), .zeroExt(zeroExt),
    .dataIn(dataIn), .dataOut(dataOut), .validOut(validOut)
  );

  sign_extend #(.DATA_WIDTH_IN(8), .DEPTH(1), .DATA_WIDTH_OUT(8)) u8 (
    .clk(clk), .rst_n(rst_n), .validIn(validIn), .zeroExt(zx1),
    .dataIn(d8), .dataOut(out8), .validOut(v8)
  );

  sign_extend #(.DATA_WIDTH_IN(8), .DEPTH(1), .DATA_WIDTH_OUT(12)) u12 (
    .clk(clk), .rst_n(rst_n), .validIn(validIn), .zeroExt(zx1),
    .dataIn(d8), .dataOut(out12), .validOut(v12)
  );

  typedef struct {
    logic [127:0] d;
    logic         v;
    logic [7:0]   d8;
    logic [11:0]  d12;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic [127:0] m_d;
  logic [7:0]   m_d8;
  logic [11:0]  m_d12;
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h", tag, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [127:0] ext_model(input logic [63:0] din,
                                             input logic [3:0] z);
    logic [127:0] r;
    logic [15:0]  lane;
    logic         neg;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      lane = din[i*16 +: 16];
      neg  = lane[15];
`ifdef SIGNEXTEND_ZEXT_EN
      if (z[i]) neg = 1'b0;
`endif
      r[i*32 +: 32] = neg ? {16'hFFFF, lane} : {16'h0000, lane};
    end
    return r;
  endfunction

  // use_c: take the literal expectation c instead of the model's value.
  task automatic drive(input logic rst, input logic v, input logic [3:0] z,
                       input logic [63:0] din, input logic [7:0] s8,
                       input logic use_c, input logic [127:0] c);
    exp_t x;
    @(negedge clk);
    rst_n = rst; validIn = v; zeroExt = z; dataIn = din; d8 = s8;
    if (!rst) begin
      m_d = '0; m_d8 = '0; m_d12 = '0;
      x.v = 1'b0;
    end else begin
      if (v) begin
        m_d   = use_c ? c : ext_model(din, z);
        m_d8  = s8;
        m_d12 = {{4{s8[7]}}, s8};
      end
      x.v = v;
    end
    x.d = m_d; x.d8 = m_d8; x.d12 = m_d12;
    q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("data",   dataOut,  e.d);
      check("valid",  validOut, {127'd0, e.v});
      check("out8",   {120'd0, out8},  {120'd0, e.d8});
      check("out12",  {116'd0, out12}, {116'd0, e.d12});
      check("v8v12",  {126'd0, v8, v12}, {126'd0, e.v, e.v});
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    logic [127:0] zc;
    zx1 = 1'b0;
    rst_n = 1'b0; validIn = 1'b0; zeroExt = '0; dataIn = '0; d8 = '0;
    m_d = '0; m_d8 = '0; m_d12 = '0;
    drive(0, 0, 4'h0, 64'h0, 8'h00, 0, '0);
    drive(0, 1, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, '0);
    drive(1, 1, 4'h0, 64'hF0007000F0007000, 8'h80, 1,
          128'hFFFFF00000007000FFFFF00000007000);
    drive(1, 1, 4'h0, 64'h7000F0007000F000, 8'h7F, 1,
          128'h00007000FFFFF00000007000FFFFF000);
    drive(1, 1, 4'h0, 64'h80007FFFFFFF0000, 8'h00, 1,
          128'hFFFF800000007FFFFFFFFFFF00000000);
    drive(1, 0, 4'h0, 64'h1234567890ABCDEF, 8'h55, 0, '0);
    drive(1, 0, 4'h0, 64'hDEADBEEFCAFEF00D, 8'hAA, 0, '0);
    drive(0, 1, 4'h0, 64'h8000800080008000, 8'h81, 0, '0);
`ifdef SIGNEXTEND_ZEXT_EN
    zc = 128'hFFFFF0000000F000FFFFF0000000F000;
`else
    zc = 128'hFFFFF000FFFFF000FFFFF000FFFFF000;
`endif
    drive(1, 1, 4'b0101, 64'hF000F000F000F000, 8'h80, 1, zc);
    for (int i = 0; i < 12; i++)
      drive(1, ($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)),
            {$urandom(), $urandom()}, 8'($urandom_range(0, 255)), 0, '0);
    drive(1, 0, 4'h0, 64'h0, 8'h00, 0, '0);
    @(negedge clk);
    @(negedge clk);
    check("drain", 128'(q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
